// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter.
//   state_t  : controller state encoding (IDLE / EXEC / DONE)
//   OP_CNT_W : width of the completed-operation counter
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OP_CNT_W = 16;

endpackage

// File: rtl/mult_arbiter_mul.sv
// Combinational signed multiplier.
//   A : A_W-bit two's-complement multiplicand
//   B : B_W-bit two's-complement multiplier
//   P : full-width (A_W+B_W) two's-complement product, never truncated
module SignedMultiplier #(
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  output logic [A_W+B_W-1:0] P
);

  // Sign-extend both operands to the product width so the multiply is
  // evaluated at full width regardless of expression sizing rules.
  logic [A_W+B_W-1:0] a_ext;
  logic [A_W+B_W-1:0] b_ext;

  assign a_ext = {{B_W{A[A_W-1]}}, A};
  assign b_ext = {{A_W{B[B_W-1]}}, B};
  assign P     = $signed(a_ext) * $signed(b_ext);

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared signed multiplier.
//   clk, rst_n             : clock, synchronous active-low reset
//   reqN_valid/ready/a/b   : operand handshake for requester N (N = 0, 1)
//   res_valid/ready/p/id   : product handshake, id = owning requester
//   busy                   : high whenever the controller is not idle
//   op_count               : completed result handshakes (wraps)
//
// state | meaning
// IDLE  | arbitrate; ready to the granted requester, accept its operands
// EXEC  | registered operands on the multiplier, capture product
// DONE  | res_valid high, result held until consumer accepts
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [A_W-1:0]        req0_a,
  input  logic [B_W-1:0]        req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [A_W-1:0]        req1_a,
  input  logic [B_W-1:0]        req1_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [A_W+B_W-1:0]    res_p,
  output logic                  res_id,
  output logic                  busy,
  output logic [OP_CNT_W-1:0]   op_count
);

  state_t             state;
  state_t             state_nxt;
  logic               last_grant;
  logic               grant_any;
  logic               grant_id;
  logic               accept;
  logic [A_W-1:0]     a_q;
  logic [B_W-1:0]     b_q;
  logic               id_q;
  logic [A_W+B_W-1:0] prod;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is gated by rst_n so no requester sees a handshake while in reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          accept     = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  SignedMultiplier #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mul (
    .A (a_q),
    .B (b_q),
    .P (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      res_p      <= '0;
      res_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        a_q        <= grant_id ? req1_a : req0_a;
        b_q        <= grant_id ? req1_b : req0_b;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        res_p  <= prod;
        res_id <= id_q;
      end
      if (res_valid && res_ready) begin
        op_count <= op_count + OP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, busy;
  logic [7:0]  res_p;
  logic [15:0] op_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt;
  logic model_last;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  mult_arbiter #(.A_W(4), .B_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_p      (res_p),
    .res_id     (res_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int ia, ib, pr;
    ia = int'(a);
    ib = int'(b);
    if (ia >= 8) ia -= 16;
    if (ib >= 8) ib -= 16;
    pr = ia * ib;
    return pr[7:0];
  endfunction

  task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
  endtask

  // Called at a falling edge with requests already driven.
  task automatic serve(input logic exp_id, input logic [7:0] exp_p, input int hold);
    int who;
    who = -1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
      @(negedge clk);
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready%0d", exp_id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    chk("grant_id", 32'(who), 32'(exp_id));
    model_last = exp_id;
    @(negedge clk);
    // Accepted requester drops out; its operand lines turn to noise.
    if (who == 1) begin
      req1_valid = 1'b0; req1_a = 4'($urandom); req1_b = 4'($urandom);
    end else begin
      req0_valid = 1'b0; req0_a = 4'($urandom); req0_b = 4'($urandom);
    end
    #1;
    chk("exec_res_valid", 32'(res_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready", 32'(req0_ready | req1_ready), 32'd0);
    @(negedge clk);
    chk("done_res_valid", 32'(res_valid), 32'd1);
    chk("done_res_p", 32'(res_p), 32'(exp_p));
    chk("done_res_id", 32'(res_id), 32'(exp_id));
    chk("done_ready", 32'(req0_ready | req1_ready), 32'd0);
    chk("done_op_count", 32'(op_count), 32'(exp_cnt[15:0]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_p", 32'(res_p), 32'(exp_p));
      chk("hold_res_id", 32'(res_id), 32'(exp_id));
      chk("hold_ready", 32'(req0_ready | req1_ready), 32'd0);
      chk("hold_op_count", 32'(op_count), 32'(exp_cnt[15:0]));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt++;
    chk("post_op_count", 32'(op_count), 32'(exp_cnt[15:0]));
    chk("post_res_valid", 32'(res_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  // Drive a request pattern, predict the winner from the round-robin rule.
  task automatic run_pair(input logic v0, input logic v1,
                          input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          input int hold);
    logic w;
    if (v0) set_req(1'b0, a0, b0);
    if (v1) set_req(1'b1, a1, b1);
    w = (v0 && v1) ? ~model_last : v1;
    serve(w, w ? ref_mul(a1, b1) : ref_mul(a0, b0), hold);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_res_p", 32'(res_p), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 0;
    model_last = 1'b1;
  endtask

  initial begin
    logic [3:0] ra0, rb0, ra1, rb1;
    logic [7:0] idx;
    logic       rv0, rv1;

    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    vecs[0] = '{1'b0, 4'hC, 4'h3, 8'hF4, 0};
    vecs[1] = '{1'b1, 4'h8, 4'h8, 8'h40, 0};
    vecs[2] = '{1'b0, 4'h8, 4'h7, 8'hC8, 0};
    vecs[3] = '{1'b1, 4'h0, 4'h8, 8'h00, 0};
    vecs[4] = '{1'b0, 4'h7, 4'h7, 8'h31, 0};
    vecs[5] = '{1'b1, 4'hF, 4'hF, 8'h01, 1};
    vecs[6] = '{1'b0, 4'h7, 4'h8, 8'hC8, 0};
    vecs[7] = '{1'b1, 4'h3, 4'hD, 8'hF7, 2};

    reset_dut();

    // Both requesters valid right after reset: req0 first, then req1.
    set_req(1'b0, 4'd2, 4'd3);
    set_req(1'b1, 4'hF, 4'd5);
    serve(1'b0, 8'h06, 0);
    serve(1'b1, 8'hFB, 0);

    foreach (vecs[i]) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b);
      serve(vecs[i].id, vecs[i].p, vecs[i].hold);
    end

    // Consumer stalls five cycles while the other requester waits.
    run_pair(1'b1, 1'b1, 4'h9, 4'h6, 4'h5, 4'hB, 5);

    // Reset during EXEC discards the operation; a pending req1 still runs.
    set_req(1'b0, 4'h5, 4'h3);
    #1;
    chk("rx_accept_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    set_req(1'b1, 4'hA, 4'h7);
    #1;
    chk("rx_ready_in_reset", 32'(req0_ready | req1_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rx_res_valid", 32'(res_valid), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_op_count", 32'(op_count), 32'd0);
    exp_cnt = 0;
    model_last = 1'b1;
    serve(1'b1, ref_mul(4'hA, 4'h7), 0);
    req1_valid = 1'b0;

    // Random request patterns against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv1 = 1'b1;
      ra0 = 4'($urandom); rb0 = 4'($urandom);
      ra1 = 4'($urandom); rb1 = 4'($urandom);
      run_pair(rv0, rv1, ra0, rb0, ra1, rb1, int'($urandom_range(0, 2)));
    end

    // Every operand pair, alternating requesters.
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      set_req(idx[0], idx[7:4], idx[3:0]);
      serve(idx[0], ref_mul(idx[7:4], idx[3:0]), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    chk("sweep_op_count", 32'(op_count), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
